ibundle_queue: RTL and testbench

Buffers fetched 128-bit instruction bundles between the instruction-cache fetch stage and the instruction decoder. Each bundle carries three 40-bit slots plus a slot-presence template. The block presents one 40-bit instruction per cycle, with its address and branch-prediction bit, to the decoder's `instr`/`predict_taken` inputs, and skips absent slots. A branch-miss/exception flush empties it in one cycle.

---
 rtl/ibundle_queue_pkg.sv | 31 +++
 rtl/ibundle_slot_sel.sv | 38 +++
 rtl/ibundle_queue.sv | 110 +++++++++++
 tb/tb_ibundle_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibundle_queue_pkg.sv
// Shared nvio3 instruction-bundle layout: field ranges, slot address offsets
// and slot-presence helpers used by the bundle queue.
package ibundle_queue_pkg;

   localparam int BUNDLE_W = 128;
   localparam int SLOT_W   = 40;
   localparam int NSLOTS   = 3;
   localparam int SLOTS_HI = 119;
   localparam int TMPL_LO  = 120;
   localparam int TMPL_HI  = 122;
   localparam int TMPL_W   = 3;

   typedef logic [1:0] slot_idx_t;

   // Byte offset of a slot within its 16-byte bundle
   function automatic logic [3:0] slot_off(input slot_idx_t idx);
      case (idx)
         2'd1:    slot_off = 4'd5;
         2'd2:    slot_off = 4'd10;
         default: slot_off = 4'd0;
      endcase
   endfunction

   function automatic slot_idx_t first_present(input logic [TMPL_W-1:0] tmpl);
      if (tmpl[0])      first_present = 2'd0;
      else if (tmpl[1]) first_present = 2'd1;
      else if (tmpl[2]) first_present = 2'd2;
      else              first_present = 2'd0;
   endfunction

endpackage

// File: rtl/ibundle_slot_sel.sv
// Combinational slot picker: current present slot at/after sp, the next
// present slot above it, whether it is the bundle's last, and the first slot.
module ibundle_slot_sel
   import ibundle_queue_pkg::*;
(
   input  logic [TMPL_W-1:0] tmpl,
   input  slot_idx_t         sp,
   output slot_idx_t         cur,
   output slot_idx_t         nxt,
   output logic              last,
   output slot_idx_t         first
);

   logic found;

   always_comb begin
      cur   = '0;
      nxt   = '0;
      last  = 1'b1;
      found = 1'b0;
      for (int i = 0; i < NSLOTS; i++) begin
         if (!found && tmpl[i] && (i >= int'(sp))) begin
            cur   = 2'(i);
            found = 1'b1;
         end
      end
      // Descending scan leaves the lowest present slot above cur in nxt
      for (int i = NSLOTS - 1; i >= 0; i--) begin
         if (tmpl[i] && (i > int'(cur))) begin
            nxt  = 2'(i);
            last = 1'b0;
         end
      end
   end

   assign first = first_present(tmpl);

endmodule

// File: rtl/ibundle_queue.sv
// Instruction bundle queue: buffers fetched bundles and hands the decoder one
// present slot per cycle, skipping absent slots; flush empties it in a cycle.
module ibundle_queue
   import ibundle_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AMSB  = 31
) (
   input  logic                   rst,
   input  logic                   clk,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [BUNDLE_W-1:0]    in_bundle,
   input  logic [AMSB:0]          in_adr,
   input  logic [NSLOTS-1:0]      in_pt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SLOT_W-1:0]      out_instr,
   output logic [AMSB:0]          out_adr,
   output logic                   out_pt,
   output logic                   out_last,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = AMSB + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [NSLOTS-1:0][SLOT_W-1:0] slot_q [DEPTH];
   logic [TMPL_W-1:0]             tmpl_q [DEPTH];
   logic [AMSB:0]                 adr_q  [DEPTH];
   logic [NSLOTS-1:0]             pt_q   [DEPTH];

   logic [PW-1:0]     wp, rp, rp_nxt;
   slot_idx_t         sp, cur, nxt, unused_first;
   logic              last, push, pop, bpop;
   logic [TMPL_W-1:0] in_tmpl;
   logic              unused_bits;

   assign in_tmpl     = in_bundle[TMPL_HI:TMPL_LO];
   assign unused_bits = ^in_bundle[BUNDLE_W-1:TMPL_HI+1];
   assign rp_nxt      = rp + PW'(1);

   ibundle_slot_sel u_sel (
      .tmpl  (tmpl_q[rp]),
      .sp    (sp),
      .cur   (cur),
      .nxt   (nxt),
      .last  (last),
      .first (unused_first)
   );

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign out_instr = slot_q[rp][cur];
   assign out_adr   = adr_q[rp] | AW'(slot_off(cur));
   assign out_pt    = pt_q[rp][cur];
   assign out_last  = last;

   // Empty-template bundles are accepted but never stored
   assign push = in_valid & in_ready & ~flush & (|in_tmpl);
   assign pop  = out_valid & out_ready & ~flush;
   assign bpop = pop & last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         sp    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
            tmpl_q[i] <= '0;
            adr_q[i]  <= '0;
            pt_q[i]   <= '0;
         end
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         sp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            slot_q[wp] <= in_bundle[SLOTS_HI:0];
            tmpl_q[wp] <= in_tmpl;
            adr_q[wp]  <= in_adr;
            pt_q[wp]   <= in_pt;
            wp         <= wp + PW'(1);
         end
         if (bpop)
            rp <= rp_nxt;
         if (push && !bpop)
            count <= count + CW'(1);
         else if (!push && bpop)
            count <= count - CW'(1);
         // sp must land on a present slot of whatever becomes the head
         if (pop) begin
            if (!last)               sp <= nxt;
            else if (count > CW'(1)) sp <= first_present(tmpl_q[rp_nxt]);
            else if (push)           sp <= first_present(in_tmpl);
            else                     sp <= '0;
         end else if (push && count == '0) begin
            sp <= first_present(in_tmpl);
         end
      end
   end

endmodule

// File: tb/tb_ibundle_queue.sv
// Bench for ibundle_queue: slot-level queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_ibundle_queue;
   import ibundle_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int AMSB  = 31;
   localparam int AW    = AMSB + 1;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic          in_ready, out_valid, out_pt, out_last;
   logic [127:0]  in_bundle;
   logic [AMSB:0] in_adr, out_adr;
   logic [2:0]    in_pt;
   logic [39:0]   out_instr;
   logic [2:0]    count;

   ibundle_queue #(.DEPTH(DEPTH), .AMSB(AMSB)) dut (
      .rst       (rst),
      .clk       (clk),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bundle (in_bundle),
      .in_adr    (in_adr),
      .in_pt     (in_pt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_adr   (out_adr),
      .out_pt    (out_pt),
      .out_last  (out_last),
      .count     (count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the queue seen as a flat list of present-slot instructions
   typedef struct {
      logic [39:0]   instr;
      logic [AMSB:0] adr;
      logic          pt;
      logic          last;
   } rec_t;

   rec_t mq[$];
   int   mcount;
   int   hi;
   bit   acc;
   rec_t r;

   always @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         mq.delete();
         mcount = 0;
      end else begin
         acc = in_valid && (mcount != DEPTH);
         if (mq.size() != 0 && out_ready) begin
            if (mq[0].last) mcount--;
            void'(mq.pop_front());
         end
         if (acc && in_bundle[122:120] != 3'b000) begin
            hi = 0;
            for (int i = 0; i < 3; i++) if (in_bundle[120+i]) hi = i;
            for (int i = 0; i < 3; i++) begin
               if (in_bundle[120+i]) begin
                  r.instr = in_bundle[40*i +: 40];
                  r.adr   = in_adr + AW'(5*i);
                  r.pt    = in_pt[i];
                  r.last  = (i == hi);
                  mq.push_back(r);
               end
            end
            mcount++;
         end
      end
   end

   always @(negedge clk) begin
      check("count", 64'(count), 64'(mcount));
      check("in_ready", 64'(in_ready), 64'(mcount != DEPTH));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("out_instr", 64'(out_instr), 64'(mq[0].instr));
         check("out_adr", 64'(out_adr), 64'(mq[0].adr));
         check("out_pt", 64'(out_pt), 64'(mq[0].pt));
         check("out_last", 64'(out_last), 64'(mq[0].last));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [AMSB:0] adr, input logic [2:0] tmpl,
                        input logic [39:0] base, input logic [2:0] pt);
      in_valid  = 1'b1;
      in_adr    = adr;
      in_pt     = pt;
      in_bundle = {5'b0, tmpl, base + 40'd2, base + 40'd1, base};
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 30 && out_valid; k++) tick();
      check(name, 64'(out_valid), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_bundle = '0; in_adr = '0; in_pt = '0;
      tick();
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      // Full three-slot bundle drains in three cycles
      out_ready = 1'b1;
      drive(32'h100, 3'b111, 40'hA0_0000_0000, 3'b010);
      tick();
      in_valid = 1'b0;
      check("t1_a_instr", 64'(out_instr), 64'hA0_0000_0000);
      check("t1_a_adr", 64'(out_adr), 64'h100);
      check("t1_a_pt", 64'(out_pt), 64'd0);
      check("t1_a_last", 64'(out_last), 64'd0);
      tick();
      check("t1_b_adr", 64'(out_adr), 64'h105);
      check("t1_b_pt", 64'(out_pt), 64'd1);
      tick();
      check("t1_c_instr", 64'(out_instr), 64'hA0_0000_0002);
      check("t1_c_adr", 64'(out_adr), 64'h10A);
      check("t1_c_last", 64'(out_last), 64'd1);
      tick();
      check("t1_empty", 64'(out_valid), 64'd0);

      // Sparse template and empty template
      drive(32'h200, 3'b101, 40'hB0_0000_0000, 3'b100);
      tick();
      in_valid = 1'b0;
      check("t2_s0_adr", 64'(out_adr), 64'h200);
      check("t2_s0_last", 64'(out_last), 64'd0);
      tick();
      check("t2_s2_instr", 64'(out_instr), 64'hB0_0000_0002);
      check("t2_s2_adr", 64'(out_adr), 64'h20A);
      check("t2_s2_pt", 64'(out_pt), 64'd1);
      check("t2_s2_last", 64'(out_last), 64'd1);
      tick();
      check("t2_empty", 64'(out_valid), 64'd0);
      drive(32'h300, 3'b000, 40'hC0_0000_0000, 3'b111);
      tick();
      in_valid = 1'b0;
      check("t2_tmpl0_count", 64'(count), 64'd0);
      check("t2_tmpl0_valid", 64'(out_valid), 64'd0);

      // Fill to DEPTH with pointer wrap, reject a fifth, then drain in order
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: drive(32'h1000, 3'b111, 40'h30_0000_0000, 3'b001);
            1: drive(32'h1010, 3'b010, 40'h30_0000_0010, 3'b010);
            2: drive(32'h1020, 3'b110, 40'h30_0000_0020, 3'b100);
            default: drive(32'h1030, 3'b001, 40'h30_0000_0030, 3'b111);
         endcase
         tick();
      end
      check("t3_full_count", 64'(count), 64'd4);
      check("t3_full_ready", 64'(in_ready), 64'd0);
      drive(32'h1040, 3'b111, 40'h30_0000_0040, 3'b000);
      tick();
      in_valid = 1'b0;
      check("t3_reject_count", 64'(count), 64'd4);
      check("t3_head_instr", 64'(out_instr), 64'h30_0000_0000);
      out_ready = 1'b1;
      drain("t3_drain");

      // Flush mid-bundle together with a push
      out_ready = 1'b0;
      drive(32'h400, 3'b111, 40'hD0_0000_0000, 3'b000);
      tick();
      drive(32'h410, 3'b111, 40'hD0_0000_0010, 3'b000);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t4_sp1_adr", 64'(out_adr), 64'h405);
      flush = 1'b1;
      drive(32'h420, 3'b111, 40'hD0_0000_0020, 3'b000);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("t4_flush_count", 64'(count), 64'd0);
      check("t4_flush_valid", 64'(out_valid), 64'd0);
      check("t4_flush_ready", 64'(in_ready), 64'd1);
      tick();
      check("t4_discarded", 64'(out_valid), 64'd0);

      // Full queue with single-slot bundles: one push per pop
      for (int k = 0; k < 4; k++) begin
         drive(32'h2000 + AW'(k*16), 3'b001, 40'h50_0000_0000 + 40'(k*16), 3'b001);
         tick();
      end
      out_ready = 1'b1;
      for (int k = 4; k < 12; k++) begin
         drive(32'h2000 + AW'(k*16), 3'b001, 40'h50_0000_0000 + 40'(k*16), 3'(k));
         tick();
      end
      in_valid = 1'b0;
      check("t5_steady_count", 64'(count), 64'd3);
      drain("t5_drain");

      // Asynchronous reset between edges
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(32'h3000 + AW'(k*16), 3'b011, 40'h60_0000_0000 + 40'(k*16), 3'b000);
         tick();
      end
      in_valid = 1'b0;
      check("t6_pre_count", 64'(count), 64'd3);
      #2 rst = 1'b1;
      #1;
      check("t6_async_count", 64'(count), 64'd0);
      check("t6_async_valid", 64'(out_valid), 64'd0);
      #2;
      drive(32'h3100, 3'b100, 40'h70_0000_0000, 3'b100);
      #1 rst = 1'b0;
      tick();
      in_valid = 1'b0;
      check("t6_first_push", 64'(count), 64'd1);
      check("t6_first_adr", 64'(out_adr), 64'h310A);
      out_ready = 1'b1;
      drain("t6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
